// File: rtl/uart_rx_bit_timing.sv
// Oversampled UART RX bit timing: edge/bit counters plus 3-tap majority vote; strobes registered, sample_valid at edge_cnt==Prescale/2+2.
// No backpressure, enable-gated only. Define UART_RX_INPUT_SYNC_EN to add a 2-flop RX_IN synchronizer (+2 cycles line-to-sample).
module uart_rx_bit_timing #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  frame_done
);

  localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [PRESCALE_W-1:0] eff_p, half;
  logic [3:0]            last_bit;
  logic                  rx_s;

`ifdef UART_RX_INPUT_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
`else
  assign rx_s = RX_IN;
`endif

  always_comb begin
    // Illegal ratios fall back to 8x so the counters always wrap.
    eff_p = P8;
    if (Prescale == P16 || Prescale == P32) eff_p = Prescale;
    half     = eff_p >> 1;
    last_bit = PAR_EN ? 4'd10 : 4'd9;

    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    s0_d           = s0_q;
    s1_d           = s1_q;
    s2_d           = s2_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;

    if (!enable) begin
      edge_cnt_d = '0;
      bit_cnt_d  = 4'd0;
      s0_d       = 1'b1;
      s1_d       = 1'b1;
      s2_d       = 1'b1;
    end else begin
      if (edge_cnt_q >= eff_p - 1'b1) begin
        edge_cnt_d = '0;
        bit_cnt_d  = (bit_cnt_q >= last_bit) ? 4'd0 : bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end

      if (edge_cnt_q == half - 1'b1) s0_d = rx_s;
      if (edge_cnt_q == half)        s1_d = rx_s;
      // Third vote is taken from the line directly so the result lands one cycle later, at Prescale/2+2.
      if (edge_cnt_q == half + 1'b1) begin
        s2_d           = rx_s;
        sampled_bit_d  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
        sample_valid_d = 1'b1;
      end

      if (edge_cnt_q == eff_p - 2'd2 && bit_cnt_q == last_bit) frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q     <= '0;
      bit_cnt_q      <= 4'd0;
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
      s2_q           <= 1'b1;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_uart_rx_bit_timing.sv
// Directed bench for uart_rx_bit_timing: table of whole frames plus hand sequences for enable drop, reset and line delay.
module tb_uart_rx_bit_timing;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       enable = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit, sample_valid, frame_done;

  uart_rx_bit_timing #(.PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .enable(enable), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
    .sample_valid(sample_valid), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  pre;
    logic        par;
    logic [7:0]  data;
    int          glitch_bit;
    int          peff;
    int          nbits;
    logic [10:0] exp_bits;
    int          exp_sv_edge;
    int          exp_done;
  } vec_t;

  vec_t vecs [4];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic par, input int idx);
    logic [7:0] dd;
    dd = d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return dd[idx-1];
    if (idx == 9 && par) return ^dd;
    return 1'b1;
  endfunction

  initial begin
    int nsv, ndone, nbad, first_sv_bit, first_sv_val;
    logic [10:0] eb;

    // pre, par, data, glitch bit, effective ratio, bits, expected sampled bits, strobe edge, done cycle
    vecs[0] = '{6'd8,  1'b0, 8'h55, -1, 8,  10, 11'h2AA, 6,  79};
    vecs[1] = '{6'd16, 1'b1, 8'hA3, -1, 16, 11, 11'h546, 10, 175};
    vecs[2] = '{6'd12, 1'b0, 8'h0F, -1, 8,  10, 11'h21E, 6,  79};
    vecs[3] = '{6'd32, 1'b0, 8'hC6, 2,  32, 10, 11'h38C, 18, 319};

    repeat (2) tick;
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_bit_cnt", int'(bit_cnt), 0);
    check("rst_sampled_bit", int'(sampled_bit), 1);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    RST = 1'b0;
    tick;

    for (int v = 0; v < 4; v++) begin
      Prescale = vecs[v].pre;
      PAR_EN   = vecs[v].par;
      enable   = 1'b0;
      RX_IN    = 1'b1;
      repeat (2) tick;
      nsv = 0;
      ndone = 0;
      eb = vecs[v].exp_bits;
      for (int k = 0; k < vecs[v].nbits * vecs[v].peff; k++) begin
        enable = 1'b1;
        RX_IN = frame_bit(vecs[v].data, vecs[v].par, k / vecs[v].peff);
        if (k / vecs[v].peff == vecs[v].glitch_bit && k % vecs[v].peff == 16) RX_IN = 1'b0;
        if (sample_valid) begin
          check($sformatf("v%0d_sv_edge", v), int'(edge_cnt), vecs[v].exp_sv_edge);
          check($sformatf("v%0d_sv_bit_cnt", v), int'(bit_cnt), nsv);
          if (nsv < 11) check($sformatf("v%0d_bit%0d_value", v, nsv), int'(sampled_bit), int'(eb[nsv]));
          nsv++;
        end
        if (frame_done) begin
          check($sformatf("v%0d_done_cycle", v), k, vecs[v].exp_done);
          check($sformatf("v%0d_done_bit_cnt", v), int'(bit_cnt), vecs[v].nbits - 1);
          check($sformatf("v%0d_done_no_sv", v), int'(sample_valid), 0);
          ndone++;
        end
        tick;
      end
      check($sformatf("v%0d_strobe_count", v), nsv, vecs[v].nbits);
      check($sformatf("v%0d_done_count", v), ndone, 1);
      check($sformatf("v%0d_wrap_edge", v), int'(edge_cnt), 0);
      check($sformatf("v%0d_wrap_bit", v), int'(bit_cnt), 0);
      enable = 1'b0;
      tick;
    end

    // Enable dropped at bit 4, edge 3; restart from 0/0 with no strobe for the abandoned bit.
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    RX_IN = 1'b1;
    nsv = 0;
    for (int k = 0; k < 35; k++) begin
      enable = 1'b1;
      if (sample_valid) nsv++;
      tick;
    end
    check("drop_at_bit", int'(bit_cnt), 4);
    check("drop_at_edge", int'(edge_cnt), 3);
    check("drop_strobes_before", nsv, 4);
    enable = 1'b0;
    nbad = 0;
    for (int j = 0; j < 5; j++) begin
      tick;
      if (sample_valid || frame_done || edge_cnt != 6'd0 || bit_cnt != 4'd0) nbad++;
    end
    check("drop_idle_violations", nbad, 0);
    enable = 1'b1;
    check("restart_edge", int'(edge_cnt), 0);
    check("restart_bit", int'(bit_cnt), 0);
    nsv = 0;
    for (int k = 0; k < 8; k++) begin
      if (sample_valid) begin
        check("restart_sv_edge", int'(edge_cnt), 6);
        check("restart_sv_bit", int'(bit_cnt), 0);
        nsv++;
      end
      tick;
    end
    check("restart_strobes", nsv, 1);
    check("restart_next_bit", int'(bit_cnt), 1);
    check("restart_next_edge", int'(edge_cnt), 0);

    // Reset pulsed at bit 7 with line held low: outputs return to reset values, no frame_done follows.
    enable = 1'b0;
    tick;
    RX_IN = 1'b0;
    for (int k = 0; k < 56; k++) begin
      enable = 1'b1;
      tick;
    end
    check("pre_rst_bit", int'(bit_cnt), 7);
    check("pre_rst_sampled", int'(sampled_bit), 0);
    RST = 1'b1;
    tick;
    check("post_rst_edge", int'(edge_cnt), 0);
    check("post_rst_bit", int'(bit_cnt), 0);
    check("post_rst_sampled", int'(sampled_bit), 1);
    check("post_rst_sv", int'(sample_valid), 0);
    check("post_rst_fd", int'(frame_done), 0);
    RST = 1'b0;
    RX_IN = 1'b1;
    ndone = 0;
    first_sv_bit = -1;
    first_sv_val = -1;
    for (int k = 0; k < 40; k++) begin
      if (frame_done) ndone++;
      if (sample_valid && first_sv_bit < 0) begin
        first_sv_bit = int'(bit_cnt);
        first_sv_val = int'(sampled_bit);
      end
      tick;
    end
    check("post_rst_done_count", ndone, 0);
    check("post_rst_first_sv_bit", first_sv_bit, 0);
    check("post_rst_first_sv_val", first_sv_val, 1);

    // Line low only on cycles 1..3 of the bit: direct feed votes 0,1,1; synchronized feed votes 0,0,0.
    enable = 1'b0;
    RX_IN = 1'b1;
    repeat (3) tick;
    nsv = 0;
    for (int k = 0; k < 8; k++) begin
      enable = 1'b1;
      RX_IN = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      if (sample_valid) begin
`ifdef UART_RX_INPUT_SYNC_EN
        check("delay_sampled", int'(sampled_bit), 0);
`else
        check("delay_sampled", int'(sampled_bit), 1);
`endif
        nsv++;
      end
      tick;
    end
    check("delay_strobes", nsv, 1);
    enable = 1'b0;
    tick;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
